uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the memory-mapped UART transmitter between NUM_REQ byte sources, e.g. CPU debug port, trap dumper and boot ROM banner.
- Acts as a bus master on the UART register word at UART_BASE:
  - polls the status byte until the transmitter is idle;
  - issues a single masked write carrying the data byte and the start bit.
- Sits beside the CPU on the SoC bus; the bus mux selects this master whenever mem_req is high.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- UART_BASE, 32'hFFFF_FFF4, word address of the UART registers: control [31:24], writeData [23:16], readData [15:8], status [7:0].
- POLL_GAP, 4, idle cycles between consecutive status polls (≥1).
- TIMEOUT_POLLS, 65535, busy polls before a byte is dropped; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-hot accept pulse
- mem_req  output  1  bus ownership request to the SoC mux
- memAddress  output  32  bus address
- memWriteData  output  32  bus write data
- memWrite  output  1  bus write strobe
- byteMask  output  4  bus byte enables
- memReadData  input  32  registered read data from the UART
- busy  output  1  high whenever the FSM is not in IDLE
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
- drop_err  output  1  one-cycle pulse when a byte is dropped; tied 0 without the macro

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, rr_ptr=0, grant_id=0;
  - all outputs 0: req_ready, mem_req, memAddress, memWriteData, memWrite, byteMask, busy, drop_err.
- Handshake: a requester holds req_valid and req_data stable until it sees req_ready=1 for one cycle. The byte is captured internally in that same cycle.
- Arbitration, IDLE state:
  - If any req_valid is high, pick the first set bit scanning from rr_ptr upward with wrap.
  - Capture that byte, pulse req_ready[i], set grant_id=i and rr_ptr=(i+1) mod NUM_REQ, then go to POLL_RD.
  - If no req_valid is high, stay in IDLE.
- POLL_RD (1 cycle): mem_req=1, memAddress=UART_BASE, memWrite=0, byteMask=4'b0000. Next state POLL_CHK.
- POLL_CHK (1 cycle): mem_req=1, address held. Sample memReadData[0], which is valid because the UART read is registered with 1 cycle latency.
  - Sample 0 → WRITE.
  - Sample 1 → GAP.
- GAP: mem_req=0; count POLL_GAP cycles, then return to POLL_RD.
- WRITE (1 cycle):
  - mem_req=1, memWrite=1, byteMask=4'b1100;
  - memWriteData={8'h01, byte, 16'h0000}, which loads writeData and sets control[0] atomically.
  - Next state SETTLE.
- SETTLE (2 cycles): mem_req=0. Lets the UART status flip to busy so it cannot be misread as idle on the next poll. Then IDLE.
- Minimum latency from accept to write strobe: 2 cycles (POLL_RD, POLL_CHK). Requester throughput is bounded by the UART frame time.
- memAddress, memWriteData and byteMask return to 0 in every state where mem_req=0.
- Boundary conditions:
  - Requests that arrive during an active transfer wait; there is no preemption.
  - With all requesters valid, grants rotate 0,1,2,3,0,…
  - A single valid requester is granted back-to-back.
  - req_valid dropped without a handshake is ignored.
  - reset_n asserted mid-transfer aborts immediately and no write is issued afterwards. A UART frame already started completes on its own.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit poll counter clears on entry to POLL_RD from IDLE and increments on every busy sample.
  - When it reaches TIMEOUT_POLLS, the byte is discarded, drop_err pulses for 1 cycle, and the FSM goes to IDLE without a write.
- Undefined: no counter; polling continues indefinitely; drop_err is constant 0.

Test Plan:
1. reset_n=0 mid-WRITE, release → all outputs 0, state IDLE, no memWrite for 10 cycles with no requests.
2. req_valid=4'b0001, data 8'h41, UART model idle → req_ready[0] pulse; 2 cycles later memWrite=1, byteMask=4'b1100, memWriteData=32'h0141_0000 at UART_BASE.
3. Status model busy for 3 polls, POLL_GAP=4 → exactly 4 read polls separated by 4 idle cycles, then one write.
4. req_valid=4'b1111 held with distinct bytes → grant_id sequence 0,1,2,3,0; each write carries the matching byte.
5. req_valid=4'b0100 only, three consecutive bytes → three back-to-back grants to 2, each preceded by a status poll.
6. UART_ARB_TIMEOUT_EN, TIMEOUT_POLLS=5, status stuck busy → drop_err pulses once after 5 polls, no memWrite, busy=0 next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one memory-mapped UART
// transmitter between NUM_REQ byte sources. Polls the status byte until the
// transmitter is idle, then issues one masked write carrying the byte and the
// start bit.
// Optional build macro: UART_ARB_TIMEOUT_EN -- drops a byte (drop_err pulse)
// after TIMEOUT_POLLS consecutive busy polls; without it polling never gives up.
//
// state      | meaning
// S_IDLE     | no transfer; round-robin pick among valid requesters
// S_POLL_RD  | status read issued at UART_BASE
// S_POLL_CHK | registered status returned; bit 0 picks write or gap
// S_GAP      | bus released for POLL_GAP cycles before the next poll
// S_WRITE    | masked write {control=8'h01, writeData=byte}
// S_SETTLE   | bus released 2 cycles so status reads busy on the next poll

module uart_tx_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter logic [31:0] UART_BASE     = 32'hFFFF_FFF4,
  parameter int          POLL_GAP      = 4,
  parameter int          TIMEOUT_POLLS = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       mem_req,
  output logic [31:0]                memAddress,
  output logic [31:0]                memWriteData,
  output logic                       memWrite,
  output logic [3:0]                 byteMask,
  input  logic [31:0]                memReadData,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       drop_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POLL_RD  = 3'd1,
    S_POLL_CHK = 3'd2,
    S_GAP      = 3'd3,
    S_WRITE    = 3'd4,
    S_SETTLE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 settle_q, settle_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 mem_write_q, mem_write_d;
  logic [3:0]           mask_q, mask_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  logic [NUM_REQ-1:0]   vld_rot;
  logic                 found;
  logic [ID_W:0]        off_w;
  logic [ID_W:0]        pick_w;
  logic [ID_W:0]        nxt_w;
  logic [7:0]           byte_sel;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_POLLS);
  logic [15:0]          poll_cnt_q, poll_cnt_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = (TIMEOUT_POLLS == 0);
`endif

  // only the idle/busy bit of the status byte matters here
  logic                 unused_rd;
  assign unused_rd = ^memReadData[31:1];

  // next-state, arbitration and registered-output decode
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    byte_d      = byte_q;
    gap_cnt_d   = gap_cnt_q;
    settle_d    = settle_q;
    req_ready_d = '0;
    drop_d      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif

    // rotate so bit 0 is the requester at rr_ptr; first set bit wins
    vld_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    found   = 1'b0;
    off_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && vld_rot[k]) begin
        found = 1'b1;
        off_w = (ID_W+1)'(k);
      end
    end
    pick_w = {1'b0, rr_ptr_q} + off_w;
    if (pick_w >= NUM_REQ_W) pick_w = pick_w - NUM_REQ_W;
    nxt_w = pick_w + 1'b1;
    byte_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_w == (ID_W+1)'(k)) byte_sel = req_data[8*k +: 8];
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_POLL_RD;
          grant_d     = pick_w[ID_W-1:0];
          byte_d      = byte_sel;
          rr_ptr_d    = (nxt_w == NUM_REQ_W) ? '0 : nxt_w[ID_W-1:0];
          req_ready_d = NUM_REQ'(1) << pick_w[ID_W-1:0];
`ifdef UART_ARB_TIMEOUT_EN
          poll_cnt_d  = '0;
`endif
        end
      end
      S_POLL_RD: state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (!memReadData[0]) begin
          state_d = S_WRITE;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          poll_cnt_d = poll_cnt_q + 16'd1;
          if (poll_cnt_q + 16'd1 == TO_CNT) begin
            state_d = S_IDLE;
            drop_d  = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
`else
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_POLL_RD;
        else gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      S_WRITE: begin
        state_d  = S_SETTLE;
        settle_d = 1'b1;
      end
      S_SETTLE: begin
        if (settle_q) settle_d = 1'b0;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // bus outputs follow the state being entered, so they are registered
    mem_req_d   = (state_d == S_POLL_RD) || (state_d == S_POLL_CHK) || (state_d == S_WRITE);
    addr_d      = mem_req_d ? UART_BASE : 32'h0;
    mem_write_d = (state_d == S_WRITE);
    mask_d      = (state_d == S_WRITE) ? 4'b1100 : 4'b0000;
    wdata_d     = (state_d == S_WRITE) ? {8'h01, byte_d, 16'h0000} : 32'h0;
    busy_d      = (state_d != S_IDLE);
  end

  // state and output registers; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      byte_q      <= '0;
      gap_cnt_q   <= '0;
      settle_q    <= 1'b0;
      req_ready_q <= '0;
      mem_req_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      byte_q      <= byte_d;
      gap_cnt_q   <= gap_cnt_d;
      settle_q    <= settle_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
`ifdef UART_ARB_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_req      = mem_req_q;
  assign memAddress   = addr_q;
  assign memWriteData = wdata_q;
  assign memWrite     = mem_write_q;
  assign byteMask     = mask_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign drop_err     = drop_q;

endmodule
